// File: rtl/seq_detect_param.sv
// Parametrised Moore serial pattern detector with overlap control and input-valid qualifier.
// Optional saturating hit counter built when SEQDET_HIT_COUNT_EN is defined.
`timescale 1ns/1ps
module seq_detect_param #(
    parameter int                     PATTERN_LEN = 4,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1010,
    parameter int                     CNT_W       = 8,
    localparam int                    SW          = $clog2(PATTERN_LEN + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          d,
    input  logic          in_valid,
    input  logic          overlap,
    output logic          out,
    output logic [SW-1:0] present,
    output logic [SW-1:0] next
`ifdef SEQDET_HIT_COUNT_EN
    ,
    output logic [CNT_W-1:0] hit_count
`endif
);

    localparam logic [SW-1:0] S_HIT = SW'(PATTERN_LEN);
    localparam int            NTBL  = 2 ** SW;

    typedef logic [SW-1:0] state_t;

    // Longest prefix of PATTERN that is a suffix of (first k pattern bits, then b).
    function automatic state_t trans(input int k, input logic b);
        int   best;
        int   idx;
        logic ok;
        logic sb;
        best = 0;
        for (int len = 1; len <= PATTERN_LEN; len++) begin
            if (len <= k + 1) begin
                ok = 1'b1;
                for (int j = 0; j < len; j++) begin
                    idx = k + 1 - len + j;
                    sb  = (idx < k) ? PATTERN[PATTERN_LEN-1-idx] : b;
                    if (sb != PATTERN[PATTERN_LEN-1-j]) ok = 1'b0;
                end
                if (ok) best = len;
            end
        end
        return SW'(best);
    endfunction

    if (PATTERN_LEN < 2 || PATTERN_LEN > 16 || CNT_W < 1 || CNT_W > 32) begin : g_param_chk
        $error("seq_detect_param: parameter out of legal range");
    end

    state_t w_f0 [NTBL];
    state_t w_f1 [NTBL];

    // Transition table is constant; entries past PATTERN_LEN are unreachable.
    for (genvar k = 0; k < NTBL; k++) begin : g_tbl
        if (k <= PATTERN_LEN) begin : g_live
            localparam state_t F0 = trans(k, 1'b0);
            localparam state_t F1 = trans(k, 1'b1);
            assign w_f0[k] = F0;
            assign w_f1[k] = F1;
        end else begin : g_pad
            assign w_f0[k] = '0;
            assign w_f1[k] = '0;
        end
    end

    state_t r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= '0;
        end else begin
            r_state <= next;
        end
    end

    // Leaving a full match without overlap restarts from the empty prefix.
    always_comb begin
        next = r_state;
        if (in_valid) begin
            if (r_state == S_HIT && !overlap) begin
                next = d ? w_f1[0] : w_f0[0];
            end else begin
                next = d ? w_f1[r_state] : w_f0[r_state];
            end
        end
    end

    assign present = r_state;
    assign out     = (r_state == S_HIT);

`ifdef SEQDET_HIT_COUNT_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (in_valid && next == S_HIT && r_cnt != {CNT_W{1'b1}}) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign hit_count = r_cnt;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param: three instances share one input stream,
// each scenario targets one instance with hand-computed state/out/count tables.
`timescale 1ns/1ps
module tb_seq_detect_param;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic d = 1'b0;
    logic in_valid = 1'b0;
    logic overlap = 1'b1;

    logic       a_out, b_out, c_out;
    logic [2:0] a_present, a_next, c_present, c_next;
    logic [1:0] b_present, b_next;
`ifdef SEQDET_HIT_COUNT_EN
    logic [7:0] a_cnt, b_cnt;
    logic [1:0] c_cnt;
`endif

    always #5 clk = ~clk;

    seq_detect_param #(.PATTERN_LEN(4), .PATTERN(4'b1010), .CNT_W(8)) u_a (
        .clk(clk), .reset(reset), .d(d), .in_valid(in_valid), .overlap(overlap),
        .out(a_out), .present(a_present), .next(a_next)
`ifdef SEQDET_HIT_COUNT_EN
        , .hit_count(a_cnt)
`endif
    );

    seq_detect_param #(.PATTERN_LEN(3), .PATTERN(3'b111), .CNT_W(8)) u_b (
        .clk(clk), .reset(reset), .d(d), .in_valid(in_valid), .overlap(overlap),
        .out(b_out), .present(b_present), .next(b_next)
`ifdef SEQDET_HIT_COUNT_EN
        , .hit_count(b_cnt)
`endif
    );

    seq_detect_param #(.PATTERN_LEN(4), .PATTERN(4'b1010), .CNT_W(2)) u_c (
        .clk(clk), .reset(reset), .d(d), .in_valid(in_valid), .overlap(overlap),
        .out(c_out), .present(c_present), .next(c_next)
`ifdef SEQDET_HIT_COUNT_EN
        , .hit_count(c_cnt)
`endif
    );

    typedef struct {
        int sel;
        bit chk_next;
        int exp_state;
        int exp_out;
        int exp_cnt;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input int sel, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, sel, act, exp, $time);
        end
    endtask

    // Monitor: next is checked mid-cycle, registered outputs just after the edge.
    initial begin : monitor
        exp_t e;
        int   st, nx, o, cn;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                case (e.sel)
                    0:       nx = int'(a_next);
                    1:       nx = int'(b_next);
                    default: nx = int'(c_next);
                endcase
                if (e.chk_next) chk("next", e.sel, nx, e.exp_state);
                @(posedge clk);
                #2;
                cn = 0;
                case (e.sel)
                    0: begin
                        st = int'(a_present); o = int'(a_out);
`ifdef SEQDET_HIT_COUNT_EN
                        cn = int'(a_cnt);
`endif
                    end
                    1: begin
                        st = int'(b_present); o = int'(b_out);
`ifdef SEQDET_HIT_COUNT_EN
                        cn = int'(b_cnt);
`endif
                    end
                    default: begin
                        st = int'(c_present); o = int'(c_out);
`ifdef SEQDET_HIT_COUNT_EN
                        cn = int'(c_cnt);
`endif
                    end
                endcase
                chk("present", e.sel, st, e.exp_state);
                chk("out", e.sel, o, e.exp_out);
`ifdef SEQDET_HIT_COUNT_EN
                chk("hit_count", e.sel, cn, e.exp_cnt);
`endif
            end
        end
    end

    task automatic step(input int sel, input logic rs, input logic v, input logic dd,
                        input logic ov, input int st, input int cnt);
        exp_t e;
        reset    = rs;
        in_valid = v;
        d        = dd;
        overlap  = ov;
        e.sel       = sel;
        e.chk_next  = !rs;
        e.exp_state = st;
        e.exp_out   = (st == ((sel == 1) ? 3 : 4)) ? 1 : 0;
        e.exp_cnt   = cnt;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Stream vectors: d bit, expected state after edge, expected count after edge.
    task automatic run(input int sel, input logic ov, input int n,
                       input logic [15:0] bits, input int sts[16], input int cnts[16]);
        step(sel, 1'b1, 1'b1, 1'b1, ov, 0, 0);
        for (int i = 0; i < n; i++) step(sel, 1'b0, 1'b1, bits[i], ov, sts[i], cnts[i]);
    endtask

    initial begin : stim
        int            waited;
        logic [15:0]   b;
        @(posedge clk);
        #1;

        // 1010 detector, overlap on: 1,0,1,0,1,0,1
        b = 16'b0000_0000_0101_0101;
        run(0, 1'b1, 7, b, '{1,2,3,4,3,4,3,0,0,0,0,0,0,0,0,0},
                           '{0,0,0,1,1,2,2,0,0,0,0,0,0,0,0,0});
        // Same stream, overlap off
        run(0, 1'b0, 7, b, '{1,2,3,4,1,2,3,0,0,0,0,0,0,0,0,0},
                           '{0,0,0,1,1,1,1,0,0,0,0,0,0,0,0,0});
        // 111 detector, five ones, overlap on then off
        b = 16'h001F;
        run(1, 1'b1, 5, b, '{1,2,3,3,3,0,0,0,0,0,0,0,0,0,0,0},
                           '{0,0,1,2,3,0,0,0,0,0,0,0,0,0,0,0});
        run(1, 1'b0, 5, b, '{1,2,3,1,2,0,0,0,0,0,0,0,0,0,0,0},
                           '{0,0,1,1,1,0,0,0,0,0,0,0,0,0,0,0});

        // 1,0,1 then a 5-cycle invalid gap with d toggling, then valid 0, then hold high
        b = 16'b0000_0000_0000_0101;
        run(0, 1'b1, 3, b, '{1,2,3,0,0,0,0,0,0,0,0,0,0,0,0,0},
                           '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0});
        for (int i = 0; i < 5; i++) step(0, 1'b0, 1'b0, i[0] ? 1'b1 : 1'b0, 1'b1, 3, 0);
        step(0, 1'b0, 1'b1, 1'b0, 1'b1, 4, 1);
        for (int i = 0; i < 3; i++) step(0, 1'b0, 1'b0, 1'b1, 1'b1, 4, 1);

        // 1,0,1, reset with valid 0 present (would have completed), then 0,1,0
        run(0, 1'b1, 3, b, '{1,2,3,0,0,0,0,0,0,0,0,0,0,0,0,0},
                           '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0});
        step(0, 1'b1, 1'b1, 1'b0, 1'b1, 0, 0);
        step(0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0);
        step(0, 1'b0, 1'b1, 1'b1, 1'b1, 1, 0);
        step(0, 1'b0, 1'b1, 1'b0, 1'b1, 2, 0);

        // CNT_W=2: 1010 then 10 x4, five detections, count saturates at 3
        b = 16'b0000_0101_0101_0101;
        run(2, 1'b1, 12, b, '{1,2,3,4,3,4,3,4,3,4,3,4,0,0,0,0},
                            '{0,0,0,1,1,2,2,3,3,3,3,3,0,0,0,0});

        waited = 0;
        while (q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        repeat (2) @(posedge clk);
        if (q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised Moore serial pattern detector for the Day-series FSM library, generalising the fixed 4-bit "1010" detector to any pattern of 2–16 bits. It adds a run-time overlap/non-overlap mode, an input-valid qualifier and an optional saturating hit counter. It sits on a single-bit serial input stream and flags each complete occurrence of the configured pattern.

## Interface
- PATTERN_LEN, 4: pattern length in bits; legal range 2..16.
- PATTERN, 4'b1010: pattern value. PATTERN[PATTERN_LEN-1] is the first bit received.
- CNT_W, 8: hit counter width; legal range 1..32.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- d  input  1  serial data bit.
- in_valid  input  1  d is consumed on a clk edge only when high.
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping; sampled every valid cycle.
- out  output  1  Moore detect flag; high while the state equals PATTERN_LEN.
- present  output  SW = $clog2(PATTERN_LEN+1)  current state, for debug.
- next  output  SW  combinational next state, for debug.
- hit_count  output  CNT_W  saturating count of detections; present only with SEQDET_HIT_COUNT_EN.

## Operation
- State k (0..PATTERN_LEN) = number of leading pattern bits currently matched.
- Transition function f(k,d) = length of the longest prefix of PATTERN that is a suffix of (first k pattern bits followed by d). f is computed at elaboration as a KMP failure table; there is no runtime table RAM.
- For k < PATTERN_LEN: next = f(k,d).
- For k = PATTERN_LEN and overlap=1: next = f(PATTERN_LEN,d).
- For k = PATTERN_LEN and overlap=0: next = f(0,d); the matched bits are discarded.
- in_valid=0: next = present. State, out and hit_count all hold.
- out = (present == PATTERN_LEN). It is purely a state decode, with no combinational path from d.
- hit_count increments by 1 on each valid edge that moves the state into PATTERN_LEN, including PATTERN_LEN→PATTERN_LEN self-loops such as pattern 111 in overlap mode.
  - hit_count saturates at 2^CNT_W−1.
- Toggling overlap mid-stream only affects the transition taken out of state PATTERN_LEN.

## Timing
- Reset: present=0, out=0, hit_count=0 on the first clk edge with reset=1. Reset overrides in_valid and d, and aborts any partial match.
- Latency: out rises in the cycle immediately after the edge that samples the last pattern bit.
- out stays high until the next valid edge. If in_valid stays low, out remains high indefinitely.
- hit_count updates on the same edge at which out rises.
- The next output is valid combinationally within the same cycle as present, d and in_valid.

## Configuration
- SEQDET_HIT_COUNT_EN defined: hit_count port and CNT_W-bit saturating counter are built.
- SEQDET_HIT_COUNT_EN undefined: the hit_count port and counter are absent. CNT_W is ignored. All other behaviour is identical.

## Test plan
- Default parameters, overlap=1, in_valid=1, d=1,0,1,0,1,0,1 → state sequence 1,2,3,4,3,4,3; out high after bits 4 and 6; hit_count=2.
- Same stream with overlap=0 → states 1,2,3,4,1,2,3; out high only after bit 4; hit_count=1.
- PATTERN_LEN=3, PATTERN=3'b111, d=1 ×5:
  - overlap=1 → out high after bits 3, 4 and 5 continuously; hit_count=3.
  - overlap=0 → out high only after bit 3; hit_count=1.
- Default parameters, stream 1,0,1 then in_valid=0 for 5 cycles with d toggling, then d=0 valid → state holds at 3 during the gap; out rises after the final 0; hit_count=1.
- Stream 1,0,1, reset pulsed for one cycle, then 0 → present=0 after reset; no detection; out stays 0.
- CNT_W=2, overlap=1, stream 1010 followed by 10 repeated 4 times → 5 detections; hit_count saturates at 3.
